// File: rtl/cacheline_burst_adaptor_pkg.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adaptor_pkg
// Shared types and constants for the cache-line <-> burst-bus adaptor.
//   LINE_BEATS / BEAT_WIDTH : geometry of one cache line on the memory bus
//   line_t                  : one full cache line
//   burst_state_t           : adaptor FSM states
// -----------------------------------------------------------------------------
package cacheline_burst_adaptor_pkg;

  localparam int unsigned LINE_BEATS = 4;
  localparam int unsigned BEAT_WIDTH = 64;
  localparam int unsigned LINE_WIDTH = LINE_BEATS * BEAT_WIDTH;

  typedef logic [LINE_WIDTH-1:0] line_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } burst_state_t;

endpackage

// File: rtl/cacheline_burst_adaptor_shift_buffer.sv
// -----------------------------------------------------------------------------
// cacheline_shift_buffer
// One cache line of storage with three access paths:
//   clk, rst       : clock, synchronous active-high reset (clears the line)
//   i_load         : load the whole line from i_load_line (wins over beat write)
//   i_wr_en        : write i_wr_beat into beat slot i_wr_idx
//   i_rd_idx       : beat slot presented combinationally on o_rd_beat
//   o_line         : full stored line
// -----------------------------------------------------------------------------
module cacheline_shift_buffer #(
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned BEATS  = 4,
  parameter int unsigned IDX_W  = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic [BEAT_W*BEATS-1:0] i_load_line,
  input  logic                    i_wr_en,
  input  logic [IDX_W-1:0]        i_wr_idx,
  input  logic [BEAT_W-1:0]       i_wr_beat,
  input  logic [IDX_W-1:0]        i_rd_idx,
  output logic [BEAT_W-1:0]       o_rd_beat,
  output logic [BEAT_W*BEATS-1:0] o_line
);

  logic [BEAT_W*BEATS-1:0] r_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_load_line;
    end else if (i_wr_en) begin
      r_line[i_wr_idx*BEAT_W +: BEAT_W] <= i_wr_beat;
    end
  end

  assign o_rd_beat = r_line[i_rd_idx*BEAT_W +: BEAT_W];
  assign o_line    = r_line;

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adaptor
// Moves 256-bit cache lines over a 64-bit burst memory bus.
//   clk, rst   : clock, synchronous active-high reset
//   Cache side : address_i, read_i, write_i, line_i (in); line_o, resp_o (out)
//   Memory side: burst_i, resp_i (in); burst_o, address_o, read_o, write_o (out)
// Reads gather BEATS beats into line_o; writebacks capture line_i at acceptance
// and stream it out beat by beat, advancing on each resp_i strobe.
// -----------------------------------------------------------------------------
module cacheline_burst_adaptor
  import cacheline_burst_adaptor_pkg::*;
#(
  parameter int unsigned BEAT_W   = BEAT_WIDTH,
  parameter int unsigned BEATS    = LINE_BEATS,
  parameter int unsigned OFFSET_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BEAT_W*BEATS-1:0] line_i,
  output logic [BEAT_W*BEATS-1:0] line_o,
  input  logic [31:0]             address_i,
  input  logic                    read_i,
  input  logic                    write_i,
  output logic                    resp_o,
  input  logic [BEAT_W-1:0]       burst_i,
  output logic [BEAT_W-1:0]       burst_o,
  output logic [31:0]             address_o,
  output logic                    read_o,
  output logic                    write_o,
  input  logic                    resp_i
);

  localparam int unsigned IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  burst_state_t            r_state;
  logic [IDX_W-1:0]        r_cnt;
  logic [31:0]             r_addr;
  logic                    r_read;
  logic                    r_write;
  logic                    r_resp;
  logic [BEAT_W-1:0]       r_burst;

  logic                    w_wb_load;
  logic                    w_rb_wr;
  logic [IDX_W-1:0]        w_nxt_idx;
  logic [BEAT_W-1:0]       w_wb_next_beat;
  logic [BEAT_W*BEATS-1:0] w_unused_wb_line;
  logic [BEAT_W-1:0]       w_unused_rb_beat;
  logic [OFFSET_W-1:0]     w_unused_offset;

  assign w_wb_load       = (r_state == ST_IDLE) && write_i && !read_i;
  assign w_rb_wr         = (r_state == ST_READ) && resp_i;
  assign w_nxt_idx       = r_cnt + IDX_W'(1);
  assign w_unused_offset = address_i[OFFSET_W-1:0];

  // Write buffer: captured at acceptance, read one slot ahead so burst_o can
  // be registered and still advance in the same cycle as resp_i.
  cacheline_shift_buffer #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS),
    .IDX_W  (IDX_W)
  ) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_wb_load),
    .i_load_line (line_i),
    .i_wr_en     (1'b0),
    .i_wr_idx    (r_cnt),
    .i_wr_beat   ('0),
    .i_rd_idx    (w_nxt_idx),
    .o_rd_beat   (w_wb_next_beat),
    .o_line      (w_unused_wb_line)
  );

  // Read assembly register drives line_o directly; it keeps the last line
  // until the next read overwrites it beat by beat.
  cacheline_shift_buffer #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS),
    .IDX_W  (IDX_W)
  ) u_rbuf (
    .clk         (clk),
    .rst         (rst),
    .i_load      (1'b0),
    .i_load_line ('0),
    .i_wr_en     (w_rb_wr),
    .i_wr_idx    (r_cnt),
    .i_wr_beat   (burst_i),
    .i_rd_idx    (r_cnt),
    .o_rd_beat   (w_unused_rb_beat),
    .o_line      (line_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
      r_burst <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_resp <= 1'b0;
          if (read_i) begin
            r_addr  <= {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
            r_cnt   <= '0;
            r_read  <= 1'b1;
            r_state <= ST_READ;
          end else if (write_i) begin
            r_addr  <= {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
            r_cnt   <= '0;
            r_write <= 1'b1;
            r_burst <= line_i[BEAT_W-1:0];
            r_state <= ST_WRITE;
          end
        end
        ST_READ: begin
          if (resp_i) begin
            if (r_cnt == LAST_IDX) begin
              r_cnt   <= '0;
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_cnt <= w_nxt_idx;
            end
          end
        end
        ST_WRITE: begin
          if (resp_i) begin
            if (r_cnt == LAST_IDX) begin
              r_cnt   <= '0;
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_cnt   <= w_nxt_idx;
              r_burst <= w_wb_next_beat;
            end
          end
        end
        ST_DONE: begin
          r_resp  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign address_o = r_addr;
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign resp_o    = r_resp;
  assign burst_o   = r_burst;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
module tb_cacheline_burst_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int unsigned n_cmp;
  int unsigned n_fail;

  cacheline_burst_adaptor #(
    .BEAT_W   (64),
    .BEATS    (4),
    .OFFSET_W (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; observe/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-back beats and their expected assembled line.
  logic [63:0] rb [4];
  logic [63:0] wb [4];

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000", {read_o, write_o, resp_o});
    end
    n_cmp++;
    if (line_o !== 256'h0 || burst_o !== 64'h0 || address_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: line_o=%h burst_o=%h address_o=%h want all 0", line_o, burst_o, address_o);
    end
  endtask

  task automatic test_read_zero_wait();
    int unsigned n_rd;
    rb[0] = 64'h1111_1111_1111_1111; rb[1] = 64'h2222_2222_2222_2222;
    rb[2] = 64'h3333_3333_3333_3333; rb[3] = 64'h4444_4444_4444_4444;
    n_rd = 0;
    read_i = 1'b1; address_i = 32'h0000_1234;
    tick();
    n_cmp++;
    if (address_o !== 32'h0000_1220) begin
      n_fail++; $display("FAIL rd_addr: got %h want 00001220", address_o);
    end
    for (int k = 0; k < 4; k++) begin
      if (read_o === 1'b1 && write_o === 1'b0 && resp_o === 1'b0) n_rd++;
      burst_i = rb[k]; resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    n_cmp++;
    if (n_rd !== 4) begin
      n_fail++; $display("FAIL rd_read_o_cycles: got %0d want 4", n_rd);
    end
    n_cmp++;
    if ({read_o, write_o, resp_o} !== 3'b001) begin
      n_fail++; $display("FAIL rd_done: ctrl got %b want 001", {read_o, write_o, resp_o});
    end
    n_cmp++;
    if (line_o !== {rb[3], rb[2], rb[1], rb[0]}) begin
      n_fail++; $display("FAIL rd_line: got %h", line_o);
    end
    read_i = 1'b0;
    tick();
    n_cmp++;
    if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== {rb[3], rb[2], rb[1], rb[0]}) begin
      n_fail++; $display("FAIL rd_after: ctrl got %b want 000, line_o=%h", {read_o, write_o, resp_o}, line_o);
    end
  endtask

  task automatic test_write_stalls();
    logic       pat [7];
    int unsigned idx;
    int unsigned n_resp;
    wb[0] = 64'h0F0F_0F0F_8899_CDEF; wb[1] = 64'hA5A5_A5A5_5A5A_5A5A;
    wb[2] = 64'hFEDC_BA98_7654_3210; wb[3] = 64'h0123_4567_89AB_CDEF;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
    idx = 0; n_resp = 0;
    write_i = 1'b1; address_i = 32'h0000_5678;
    line_i = {wb[3], wb[2], wb[1], wb[0]};
    tick();
    n_cmp++;
    if (address_o !== 32'h0000_5660 || write_o !== 1'b1 || read_o !== 1'b0) begin
      n_fail++; $display("FAIL wr_start: address_o=%h want 00005660, write_o=%b read_o=%b", address_o, write_o, read_o);
    end
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (burst_o !== wb[idx] || write_o !== 1'b1) begin
        n_fail++; $display("FAIL wr_beat%0d: burst_o=%h want %h write_o=%b", k, burst_o, wb[idx], write_o);
      end
      if (resp_o === 1'b1) n_resp++;
      resp_i = pat[k];
      tick();
      if (pat[k]) idx++;
    end
    resp_i = 1'b0;
    n_cmp++;
    if ({read_o, write_o, resp_o} !== 3'b001) begin
      n_fail++; $display("FAIL wr_done: ctrl got %b want 001", {read_o, write_o, resp_o});
    end
    if (resp_o === 1'b1) n_resp++;
    write_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (resp_o === 1'b1) n_resp++;
    end
    n_cmp++;
    if (n_resp !== 1 || write_o !== 1'b0) begin
      n_fail++; $display("FAIL wr_resp_count: got %0d want 1, write_o=%b", n_resp, write_o);
    end
  endtask

  task automatic test_simultaneous();
    logic [63:0] b [4];
    int unsigned n_bad;
    b[0] = 64'hAAAA_0000_0000_0001; b[1] = 64'hAAAA_0000_0000_0002;
    b[2] = 64'hAAAA_0000_0000_0003; b[3] = 64'hAAAA_0000_0000_0004;
    n_bad = 0;
    $display("note: driving read_i and write_i together (protocol error) - read must win");
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_ABCD;
    line_i = {4{64'hDEAD_BEEF_DEAD_BEEF}};
    tick();
    n_cmp++;
    if (address_o !== 32'h0000_ABC0) begin
      n_fail++; $display("FAIL sim_addr: got %h want 0000abc0", address_o);
    end
    for (int k = 0; k < 4; k++) begin
      if (read_o !== 1'b1 || write_o !== 1'b0) n_bad++;
      burst_i = b[k]; resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    n_cmp++;
    if (n_bad !== 0) begin
      n_fail++; $display("FAIL sim_only_read: bad cycles got %0d want 0", n_bad);
    end
    n_cmp++;
    if (resp_o !== 1'b1 || write_o !== 1'b0 || line_o !== {b[3], b[2], b[1], b[0]}) begin
      n_fail++; $display("FAIL sim_done: resp_o=%b write_o=%b line_o=%h", resp_o, write_o, line_o);
    end
    read_i = 1'b0; write_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] b [4];
    int unsigned n_resp;
    b[0] = 64'h5555_0000_0000_0000; b[1] = 64'h5555_1111_0000_0000;
    b[2] = 64'h5555_2222_0000_0000; b[3] = 64'h5555_3333_0000_0000;
    n_resp = 0;
    read_i = 1'b1; address_i = 32'h1000_0040;
    tick();
    for (int k = 0; k < 2; k++) begin
      burst_i = 64'hBAD0_BAD0_0000_0000 + 64'(k); resp_i = 1'b1;
      tick();
    end
    rst = 1'b1; resp_i = 1'b0; read_i = 1'b0;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== 256'h0 || burst_o !== 64'h0 || address_o !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: ctrl=%b line_o=%h burst_o=%h address_o=%h want all 0", {read_o, write_o, resp_o}, line_o, burst_o, address_o);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (resp_o === 1'b1 || read_o === 1'b1) n_resp++;
    end
    n_cmp++;
    if (n_resp !== 0) begin
      n_fail++; $display("FAIL mid_reset_quiet: activity cycles got %0d want 0", n_resp);
    end
    read_i = 1'b1; address_i = 32'h2000_007F;
    tick();
    for (int k = 0; k < 4; k++) begin
      burst_i = b[k]; resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    n_cmp++;
    if (resp_o !== 1'b1 || address_o !== 32'h2000_0060 || line_o !== {b[3], b[2], b[1], b[0]}) begin
      n_fail++; $display("FAIL post_reset_read: resp_o=%b address_o=%h line_o=%h", resp_o, address_o, line_o);
    end
    read_i = 1'b0;
    tick();
  endtask

  task automatic test_perturb();
    logic [63:0] w [4];
    int unsigned n_bad;
    w[0] = 64'hC0C0_0000_0000_0000; w[1] = 64'hC1C1_0000_0000_0001;
    w[2] = 64'hC2C2_0000_0000_0002; w[3] = 64'hC3C3_0000_0000_0003;
    n_bad = 0;
    // Spurious memory strobes while idle.
    burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      resp_i = 1'b1;
      tick();
      if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h2000_0060) n_bad++;
    end
    resp_i = 1'b0;
    n_cmp++;
    if (n_bad !== 0 || line_o !== {64'h5555_3333_0000_0000, 64'h5555_2222_0000_0000, 64'h5555_1111_0000_0000, 64'h5555_0000_0000_0000}) begin
      n_fail++; $display("FAIL idle_resp_i: bad cycles %0d want 0, line_o=%h", n_bad, line_o);
    end
    write_i = 1'b1; address_i = 32'h8000_0040;
    line_i = {w[3], w[2], w[1], w[0]};
    tick();
    address_i = 32'hFFFF_FFFF; line_i = {4{64'h9999_9999_9999_9999}};
    n_bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (burst_o !== w[0] || address_o !== 32'h8000_0040 || resp_o !== 1'b0) n_bad++;
    end
    n_cmp++;
    if (n_bad !== 0) begin
      n_fail++; $display("FAIL stall_hold: bad cycles got %0d want 0 (burst_o=%h address_o=%h)", n_bad, burst_o, address_o);
    end
    n_bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (burst_o !== w[k]) n_bad++;
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    n_cmp++;
    if (n_bad !== 0 || resp_o !== 1'b1 || write_o !== 1'b0) begin
      n_fail++; $display("FAIL perturb_write: bad beats %0d want 0, resp_o=%b write_o=%b", n_bad, resp_o, write_o);
    end
    write_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int unsigned n_resp;
    n_resp = 0;
    write_i = 1'b1; address_i = 32'h0000_0100;
    line_i = {wb[3], wb[2], wb[1], wb[0]};
    tick();
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    if (resp_o === 1'b1) n_resp++;
    write_i = 1'b0; read_i = 1'b1; address_i = 32'h0000_0200;
    tick();
    n_cmp++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      n_fail++; $display("FAIL b2b_idle: ctrl got %b want 000", {read_o, write_o, resp_o});
    end
    tick();
    n_cmp++;
    if (read_o !== 1'b1 || write_o !== 1'b0 || address_o !== 32'h0000_0200) begin
      n_fail++; $display("FAIL b2b_read_start: read_o=%b write_o=%b address_o=%h", read_o, write_o, address_o);
    end
    for (int k = 0; k < 4; k++) begin
      burst_i = rb[3-k]; resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    if (resp_o === 1'b1) n_resp++;
    n_cmp++;
    if (line_o !== {rb[0], rb[1], rb[2], rb[3]}) begin
      n_fail++; $display("FAIL b2b_line: got %h", line_o);
    end
    read_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (resp_o === 1'b1) n_resp++;
    end
    n_cmp++;
    if (n_resp !== 2) begin
      n_fail++; $display("FAIL b2b_resp_count: got %0d want 2", n_resp);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    test_reset();
    test_read_zero_wait();
    test_write_stalls();
    test_simultaneous();
    test_reset_mid_burst();
    test_perturb();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
Memory-side partner of the cache line write-merge path. Takes whole 256-bit cache lines from the cache's physical-memory port and moves them over a 64-bit burst memory bus. Reads assemble 4 incoming beats into one line; writebacks serialise one line into 4 outgoing beats. Sits between the cache datapath/controller and physical memory, one per cache.

Parameters:
BEAT_W, 64, width of one memory bus beat in bits
BEATS, 4, beats per cache line; line width is BEAT_W*BEATS = 256
OFFSET_W, 5, line-offset bits zeroed on the outgoing address

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
line_i  in  256  line to write back; sampled only on writeback acceptance
line_o  out  256  assembled read line; valid while resp_o=1
address_i  in  32  cache-side line address
read_i  in  1  cache line-read request; held until resp_o
write_i  in  1  cache line-writeback request; held until resp_o
resp_o  out  1  one-cycle completion pulse to cache
burst_i  in  64  read beat from memory
burst_o  out  64  write beat to memory
address_o  out  32  memory address, {address_i[31:5], 5'b0} latched at acceptance
read_o  out  1  memory burst-read request
write_o  out  1  memory burst-write request
resp_i  in  1  memory beat strobe, one per beat

Behaviour:
- States: IDLE, READ, WRITE, DONE; 2-bit beat counter (0..BEATS-1).
- Reset (rst=1 at a rising edge): state IDLE, counter 0, line_o=0, burst_o=0, address_o=0, read_o=write_o=resp_o=0. Applies mid-burst: the transfer is abandoned and no resp_o is produced.
- IDLE, read_i=1:
  - latch address_o={address_i[31:5],5'b0}, counter=0, go to READ.
  - read_o=1 from the next cycle.
- IDLE, write_i=1, read_i=0:
  - latch address_o, latch line_i into an internal write buffer, counter=0, go to WRITE.
  - write_o=1 and burst_o=line_i[63:0] from the next cycle.
- read_i and write_i both high in IDLE: read wins. This is a protocol error; the bench flags it.
- READ: on each cycle with resp_i=1:
  - line_o[64*counter +: 64] <= burst_i, counter++.
  - On the beat with counter=BEATS-1: read_o drops next cycle, go to DONE.
- WRITE: burst_o always shows buffer[64*counter +: 64]. On each resp_i=1, counter++. On the beat with counter=BEATS-1: write_o drops next cycle, go to DONE.
- resp_i=0 in READ/WRITE: hold state, counter and outputs; stalls have no limit.
- DONE:
  - resp_o=1 for exactly one cycle, then IDLE.
  - For a read, line_o holds the assembled line in DONE and is unchanged until the next read's first beat.
  - Requests are not sampled in DONE. The cache drops its request after resp_o, so no back-to-back re-trigger occurs.
- resp_i in IDLE or DONE is ignored.
- address_i/line_i changes after acceptance are ignored.
- Latency, zero memory wait: accept at edge 0; read_o/write_o high in cycles 1..4; resp_o in cycle 5. Minimum 6 cycles request-to-IDLE.
- Counter wraps 3->0 only on the transition to DONE.
- read_o and write_o are never high together.

Decomposition:
- Shared package rv32i_types: add typedef of the 4-state enum, a line typedef (logic [255:0]), and constants LINE_BEATS=4, BEAT_WIDTH=64.
- Natural sub-module: cacheline_shift_buffer, a 256-bit buffer holding load-line, indexed beat write and indexed beat read. It serves as the write buffer and as the line_o assembly register.
- The FSM stays in the top module.

Test Plan:
- Read, zero wait: read_i=1, address_i=0x0000_1234; memory returns beats 0x1111..11, 0x2222..22, 0x3333..33, 0x4444..44 in consecutive cycles.
  - Required: address_o=0x0000_1220 and read_o high for 4 cycles.
  - Required: resp_o one cycle later with line_o={0x4444..44, 0x3333..33, 0x2222..22, 0x1111..11}.
- Writeback with stalls: write_i=1, line_i=256'h0123_..._CDEF, resp_i pattern 1,0,0,1,1,0,1.
  - Required: burst_o steps through line_i[63:0], [127:64], [191:128], [255:192], advancing only on resp_i=1.
  - Required: write_o drops after the 4th beat; exactly one resp_o.
- Simultaneous read_i=write_i=1 in IDLE -> only read_o asserts, write_o stays 0, one read burst performed.
- Reset after 2 read beats -> next cycle all outputs 0, state IDLE, no resp_o. A following read completes normally with a fresh 4-beat count.
- Input perturbation: spurious resp_i pulses in IDLE, and address_i/line_i changed mid-burst -> no state change, no resp_o; address_o and burst_o keep their latched values.
- Back-to-back: writeback followed immediately by a read (cache drops write_i after resp_o, raises read_i) -> second transfer starts the cycle after IDLE is re-entered; each transfer gets exactly one resp_o.
